// File: rtl/ascon_dec_pkg.sv
// ---------------------------------------------------------------------------
// ascon_dec_pkg: shared types and constants for the ASCON-128 decrypt FSM.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package ascon_dec_pkg;

  typedef enum logic [4:0] {
    S_IDLE      = 5'd0,
    S_LOAD      = 5'd1,
    S_P_INIT    = 5'd2,
    S_POST_INIT = 5'd3,
    S_WAIT_AD   = 5'd4,
    S_ABS_AD    = 5'd5,
    S_P_AD      = 5'd6,
    S_POST_AD   = 5'd7,
    S_WAIT_CT   = 5'd8,
    S_DEC_CT    = 5'd9,
    S_P_CT      = 5'd10,
    S_FIN_KEY   = 5'd11,
    S_P_FIN     = 5'd12,
    S_POST_FIN  = 5'd13,
    S_WAIT_TAG  = 5'd14,
    S_CHECK     = 5'd15,
    S_DONE      = 5'd16
  } state_t;

  localparam logic [3:0] RND_P12_START = 4'd0;
  localparam logic [3:0] RND_P6_START  = 4'd6;
  localparam logic [3:0] RND_LAST      = 4'd11;

  localparam logic [1:0] XU_AD       = 2'b00;
  localparam logic [1:0] XU_CT       = 2'b01;
  localparam logic [1:0] XU_KEY      = 2'b10;
  localparam logic [1:0] XD_KEY_INIT = 2'b00;
  localparam logic [1:0] XD_DOMAIN   = 2'b01;
  localparam logic [1:0] XD_KEY_FIN  = 2'b10;

  typedef struct packed {
    logic       ena_reg_state;
    logic       perm_en;
    logic       init_state;
    logic       ena_xor_up;
    logic [1:0] conf_xor_up;
    logic       ena_xor_down;
    logic [1:0] conf_xor_down;
    logic       data_ack;
    logic       plain_valid;
    logic       done;
  } ctrl_t;

  // Moore decode of the datapath controls for a given state.
  function automatic ctrl_t decode(state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_LOAD: begin
        c.ena_reg_state = 1'b1;
        c.init_state    = 1'b1;
      end
      S_P_INIT, S_P_AD, S_P_CT, S_P_FIN: begin
        c.ena_reg_state = 1'b1;
        c.perm_en       = 1'b1;
      end
      S_POST_INIT: begin
        c.ena_reg_state = 1'b1;
        c.ena_xor_down  = 1'b1;
        c.conf_xor_down = XD_KEY_INIT;
      end
      S_ABS_AD: begin
        c.ena_reg_state = 1'b1;
        c.ena_xor_up    = 1'b1;
        c.conf_xor_up   = XU_AD;
        c.data_ack      = 1'b1;
      end
      S_POST_AD: begin
        c.ena_reg_state = 1'b1;
        c.ena_xor_down  = 1'b1;
        c.conf_xor_down = XD_DOMAIN;
      end
      S_DEC_CT: begin
        c.ena_reg_state = 1'b1;
        c.ena_xor_up    = 1'b1;
        c.conf_xor_up   = XU_CT;
        c.data_ack      = 1'b1;
        c.plain_valid   = 1'b1;
      end
      S_FIN_KEY: begin
        c.ena_reg_state = 1'b1;
        c.ena_xor_up    = 1'b1;
        c.conf_xor_up   = XU_KEY;
      end
      S_POST_FIN: begin
        c.ena_reg_state = 1'b1;
        c.ena_xor_down  = 1'b1;
        c.conf_xor_down = XD_KEY_FIN;
      end
      S_DONE: c.done = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ascon_round_cpt.sv
// ---------------------------------------------------------------------------
// ascon_round_cpt: 4-bit permutation round counter, load has priority. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ascon_round_cpt (
  input  logic       clock,
  input  logic       resetb,
  input  logic       load,
  input  logic [3:0] load_value,
  input  logic       enable,
  output logic [3:0] count
);

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      count <= 4'd0;
    end else if (load) begin
      count <= load_value;
    end else if (enable) begin
      count <= count + 4'd1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/ascon_dec_fsm.sv
// ---------------------------------------------------------------------------
// ascon_dec_fsm: ASCON-128 decryption controller (init, AD, NB_CT blocks,
// finalization, tag check). Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ascon_dec_fsm
  import ascon_dec_pkg::*;
#(
  parameter int NB_CT = 4
) (
  input  logic       clock_i,
  input  logic       resetb_i,
  input  logic       start_i,
  input  logic       data_valid_i,
  input  logic       tag_valid_i,
  input  logic       tag_match_i,
  output logic       ena_reg_state_o,
  output logic       perm_en_o,
  output logic [3:0] round_o,
  output logic       init_state_o,
  output logic       ena_xor_up_o,
  output logic [1:0] conf_xor_up_o,
  output logic       ena_xor_down_o,
  output logic [1:0] conf_xor_down_o,
  output logic       data_ack_o,
  output logic       plain_valid_o,
  output logic [2:0] block_o,
  output logic       auth_ok_o,
  output logic       end_o
);

  state_t     state;
  state_t     state_nxt;
  ctrl_t      ctrl;
  logic [3:0] rnd;
  logic [2:0] blk;
  logic       auth_ok;
  logic       rnd_load;
  logic [3:0] rnd_load_val;
  logic       is_perm;
  logic       rnd_last;
  logic       blk_last;

  assign is_perm  = (state == S_P_INIT) || (state == S_P_AD) ||
                    (state == S_P_CT)   || (state == S_P_FIN);
  assign rnd_last = (rnd == RND_LAST);
  assign blk_last = (blk == 3'(NB_CT - 1));

  always_comb begin
    rnd_load     = 1'b0;
    rnd_load_val = RND_P12_START;
    case (state)
      S_LOAD, S_FIN_KEY: rnd_load = 1'b1;
      S_ABS_AD: begin
        rnd_load     = 1'b1;
        rnd_load_val = RND_P6_START;
      end
      S_DEC_CT: begin
        rnd_load     = !blk_last;
        rnd_load_val = RND_P6_START;
      end
      default: rnd_load = 1'b0;
    endcase
  end

  ascon_round_cpt u_round_cpt (
    .clock      (clock_i),
    .resetb     (resetb_i),
    .load       (rnd_load),
    .load_value (rnd_load_val),
    .enable     (is_perm),
    .count      (rnd)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (start_i) state_nxt = S_LOAD;
      S_LOAD:      state_nxt = S_P_INIT;
      S_P_INIT:    if (rnd_last) state_nxt = S_POST_INIT;
      S_POST_INIT: state_nxt = data_valid_i ? S_ABS_AD : S_WAIT_AD;
      S_WAIT_AD:   if (data_valid_i) state_nxt = S_ABS_AD;
      S_ABS_AD:    state_nxt = S_P_AD;
      S_P_AD:      if (rnd_last) state_nxt = S_POST_AD;
      S_POST_AD:   state_nxt = data_valid_i ? S_DEC_CT : S_WAIT_CT;
      S_WAIT_CT:   if (data_valid_i) state_nxt = S_DEC_CT;
      S_DEC_CT:    state_nxt = blk_last ? S_FIN_KEY : S_P_CT;
      S_P_CT:      if (rnd_last) state_nxt = data_valid_i ? S_DEC_CT : S_WAIT_CT;
      S_FIN_KEY:   state_nxt = S_P_FIN;
      S_P_FIN:     if (rnd_last) state_nxt = S_POST_FIN;
      S_POST_FIN:  state_nxt = tag_valid_i ? S_CHECK : S_WAIT_TAG;
      S_WAIT_TAG:  if (tag_valid_i) state_nxt = S_CHECK;
      S_CHECK:     state_nxt = S_DONE;
      S_DONE:      if (start_i) state_nxt = S_LOAD;
      default:     state_nxt = S_IDLE;
    endcase
  end

  // Controls are decoded from the next state so they line up with the state.
  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      state   <= S_IDLE;
      ctrl    <= '0;
      blk     <= 3'd0;
      auth_ok <= 1'b0;
    end else begin
      state <= state_nxt;
      ctrl  <= decode(state_nxt);
      if (state == S_LOAD) begin
        blk     <= 3'd0;
        auth_ok <= 1'b0;
      end
      if (state == S_DEC_CT) blk <= blk + 3'd1;
      if (state == S_CHECK) auth_ok <= tag_match_i;
    end
  end

  assign ena_reg_state_o = ctrl.ena_reg_state;
  assign perm_en_o       = ctrl.perm_en;
  assign round_o         = rnd;
  assign init_state_o    = ctrl.init_state;
  assign ena_xor_up_o    = ctrl.ena_xor_up;
  assign conf_xor_up_o   = ctrl.conf_xor_up;
  assign ena_xor_down_o  = ctrl.ena_xor_down;
  assign conf_xor_down_o = ctrl.conf_xor_down;
  assign data_ack_o      = ctrl.data_ack;
  assign plain_valid_o   = ctrl.plain_valid;
  assign block_o         = blk;
  assign auth_ok_o       = auth_ok;
  assign end_o           = ctrl.done;

endmodule

`default_nettype wire
